aes_byte_scanner: RTL
=====================

# aes_byte_scanner

Sequential result presenter between the AES cipher/decipher outputs and the `bcdto7seg` display decoder. It captures a 128-bit block on a start pulse and walks it byte by byte, most-significant byte first. Each byte is converted to 3-digit BCD with an iterative shift-add-3 (double dabble) engine and held for a programmable dwell time. It also reports whether the captured block equals a supplied expected value, which replaces the free-running byte-0-only display and ad-hoc compare logic at top level.

## Interface
- `DWELL`, default 50_000_000: cycles each converted byte is held valid (1 s at 50 MHz); must be ≥ 1.
- `DWELL_W`, default 26: width of the dwell counter; must satisfy 2^DWELL_W > DWELL.

- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to capture and scan `block_in`.
- `block_in`  in  128  block to display (cipher or decipher result).
- `expected`  in  128  reference block for the match check.
- `busy`  out  1  high from start acceptance until scan completes.
- `done`  out  1  one-cycle pulse at scan completion.
- `byte_idx`  out  4  index of the byte being converted/shown; 0 = `block_in[127:120]`.
- `bcd_out`  out  12  BCD of the current byte: [11:8] hundreds, [7:4] tens, [3:0] units.
- `bcd_valid`  out  1  high while `bcd_out` holds a completed conversion for `byte_idx`.
- `match`  out  1  registered result of `block_in == expected` at capture.

## Operation
- Reset values: `busy`=0, `done`=0, `byte_idx`=0, `bcd_out`=12'h000, `bcd_valid`=0, `match`=0, state IDLE, dwell counter 0.
- States: IDLE, CONVERT, SHOW, DONE.
- IDLE: `start`=1 captures `block_in` and `expected`, registers `match`, clears `byte_idx`, asserts `busy`, and enters CONVERT. `start` is ignored in all other states.
- CONVERT: 8 iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts in the next byte bit, MSB first. `bcd_out` keeps its previous value and `bcd_valid`=0. After iteration 8 the result loads into `bcd_out`, `bcd_valid`=1, and the state moves to SHOW.
- SHOW: the dwell counter counts DWELL cycles. At terminal count, `bcd_valid`=0 and the counter clears. If `byte_idx`=15 the state moves to DONE; otherwise `byte_idx` increments and the state moves to CONVERT.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then IDLE. `bcd_out`, `byte_idx` (15) and `match` hold until the next accepted start.
- Value range: bytes 0..255 map to BCD 0x000..0x255, so the hundreds nibble never exceeds 2.
- Reset mid-operation: all state and outputs return to reset values immediately; no partial `done` pulse is produced.

## Timing
- Let edge 0 be the edge that samples `start`=1 in IDLE.
- Byte k: `bcd_valid` rises after edge 8 + k·(8+DWELL) and stays high for exactly DWELL cycles.
- `done` rises after edge 16·(8+DWELL) together with the fall of `busy`, and lasts one cycle.
- `match` is valid after edge 0 and is stable for the whole scan.
- A new `start` is accepted no earlier than the edge after the DONE cycle.

## Configuration
- `AES_SCAN_COMPARE_EN` defined: `expected` is captured and `match` behaves as specified.
- Not defined: the compare logic and the `expected` capture register are removed, `expected` is ignored, and `match` is tied to 0.

## Structure
- Shared package holds the state enumeration (IDLE/CONVERT/SHOW/DONE), the block width (128), the byte count (16), and the BCD width (12).
- One sub-module, `bcd_dabble_step`: combinational single double-dabble iteration (adjust-then-shift over a 12-bit BCD and 8-bit binary shift register), instantiated once and iterated by the FSM.

## Test plan
- DWELL=4, `block_in`=`expected`=128'h69c4e0d86a7b0430d8cdb78070b4c55a, one start pulse. Required:
  - `match`=1.
  - First `bcd_out`=12'h105 valid after edge 8.
  - Byte 1 shows 12'h196.
  - Last byte shows 12'h090.
  - `done` after edge 192.
- Bytes 0x00 and 0xff (`block_in`=128'h00ff…) -> `bcd_out` 12'h000 then 12'h255.
- Same stimulus as the first scenario with `expected`=128'h0 -> `match`=0 and the BCD sequence unchanged. Without `AES_SCAN_COMPARE_EN`, `match`=0 in all cases.
- `start` pulsed again at edge 20 during a scan -> ignored; `byte_idx` sequence and `done` timing unchanged.
- `reset` asserted during byte 5 SHOW -> all outputs return to reset values immediately. A following start rescans from byte 0.
- DWELL=1 -> each `bcd_valid` pulse is exactly one cycle wide and bytes are spaced 9 cycles apart.

Source files
------------

// File: rtl/aes_byte_scanner_pkg.sv
// Shared types and sizes for the AES result byte scanner.
package aes_byte_scanner_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned NBYTES  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHOW,
    DONE
  } scan_state_e;

endpackage

// File: rtl/aes_byte_scanner_dabble.sv
// One combinational double-dabble iteration: add-3 on nibbles >= 5, then shift left by one.
module bcd_dabble_step
  import aes_byte_scanner_pkg::*;
(
  input  logic [BCD_W-1:0]  bcd_in,
  input  logic [BYTE_W-1:0] bin_in,
  output logic [BCD_W-1:0]  bcd_out,
  output logic [BYTE_W-1:0] bin_out
);

  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = bcd_in;
    for (int unsigned n = 0; n < BCD_W / 4; n++) begin
      if (adj[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
      end
    end
    bcd_out = {adj[BCD_W-2:0], bin_in[BYTE_W-1]};
    bin_out = {bin_in[BYTE_W-2:0], 1'b0};
  end

endmodule

// File: rtl/aes_byte_scanner.sv
// Captures a 128-bit block and presents it MSB byte first as dwell-held 3-digit BCD.
// Optional block/expected compare enabled by defining AES_SCAN_COMPARE_EN.
module aes_byte_scanner
  import aes_byte_scanner_pkg::*;
#(
  parameter int unsigned DWELL   = 50_000_000,
  parameter int unsigned DWELL_W = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BLOCK_W-1:0] block_in,
  input  logic [BLOCK_W-1:0] expected,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   byte_idx,
  output logic [BCD_W-1:0]   bcd_out,
  output logic               bcd_valid,
  output logic               match
);

  if (DWELL < 1) begin : g_bad_dwell
    $error("aes_byte_scanner: DWELL must be at least 1");
  end
  if ((64'd1 << DWELL_W) <= 64'(DWELL)) begin : g_bad_dwell_w
    $error("aes_byte_scanner: DWELL_W too narrow for DWELL");
  end

  localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NBYTES - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(BYTE_W - 1);

  scan_state_e          state;
  logic [BLOCK_W-1:0]   block_q;
  logic [BYTE_W-1:0]    bin_work;
  logic [BCD_W-1:0]     bcd_work;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic [BCD_W-1:0]     step_bcd;
  logic [BYTE_W-1:0]    step_bin;
  logic                 match_now;

`ifdef AES_SCAN_COMPARE_EN
  assign match_now = (block_in == expected);
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign match_now       = 1'b0;
`endif

  bcd_dabble_step u_step (
    .bcd_in  (bcd_work),
    .bin_in  (bin_work),
    .bcd_out (step_bcd),
    .bin_out (step_bin)
  );

  // The captured block is shifted left a byte at a time so the next byte is always block_q[127:120].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      block_q   <= '0;
      bin_work  <= '0;
      bcd_work  <= '0;
      bit_cnt   <= '0;
      dwell_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      byte_idx  <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      match     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            block_q  <= {block_in[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            bin_work <= block_in[BLOCK_W-1 -: BYTE_W];
            bcd_work <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            busy     <= 1'b1;
            match    <= match_now;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_work <= step_bcd;
          bin_work <= step_bin;
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bcd_out   <= step_bcd;
            bcd_valid <= 1'b1;
            state     <= SHOW;
          end
        end
        SHOW: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            bcd_valid <= 1'b0;
            if (byte_idx == IDX_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              bin_work <= block_q[BLOCK_W-1 -: BYTE_W];
              block_q  <= {block_q[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
              bcd_work <= '0;
              bit_cnt  <= '0;
              state    <= CONVERT;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
